// File: rtl/glb_cluster_seq.sv
// glb_cluster_seq: job sequencer for one GLB cluster.
// Loads the iact and weight GLBs from one stream, waits for compute, then drains the psum GLB.
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   start, num_*         job start pulse and word counts (latched at start)
//   compute_done         PE cluster finished
//   in_data/valid/ready  load stream
//   write_en/w_addr/w_data_{iact,wght}  GLB write ports
//   read_req_psum, r_addr_psum, r_data_psum  psum GLB read port (1-cycle latency)
//   psum_out_data/valid/ready  drain stream
//   compute_start, busy, done  job status
module glb_cluster_seq #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_BITWIDTH-1:0] num_iact,
  input  logic [ADDR_BITWIDTH-1:0] num_wght,
  input  logic [ADDR_BITWIDTH-1:0] num_psum,
  input  logic                     compute_done,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     write_en_iact,
  output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
  output logic [DATA_BITWIDTH-1:0] w_data_iact,
  output logic                     write_en_wght,
  output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
  output logic [DATA_BITWIDTH-1:0] w_data_wght,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic [DATA_BITWIDTH-1:0] psum_out_data,
  output logic                     psum_out_valid,
  input  logic                     psum_out_ready,
  output logic                     compute_start,
  output logic                     busy,
  output logic                     done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IACT  = 3'd1;
  localparam logic [2:0] S_WGHT  = 3'd2;
  localparam logic [2:0] S_COMP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_BITWIDTH-1:0] L_ONE =
    {{(ADDR_BITWIDTH-1){1'b0}}, 1'b1};

  logic [2:0]               r_state;
  logic [2:0]               w_next;
  logic [ADDR_BITWIDTH-1:0] r_cnt;
  logic [ADDR_BITWIDTH-1:0] r_num_iact;
  logic [ADDR_BITWIDTH-1:0] r_num_wght;
  logic [ADDR_BITWIDTH-1:0] r_num_psum;
  logic                     r_we_iact;
  logic [ADDR_BITWIDTH-1:0] r_wa_iact;
  logic [DATA_BITWIDTH-1:0] r_wd_iact;
  logic                     r_we_wght;
  logic [ADDR_BITWIDTH-1:0] r_wa_wght;
  logic [DATA_BITWIDTH-1:0] r_wd_wght;
  logic                     r_cstart;
  logic                     r_out_valid;
  logic                     r_fresh;
  logic [DATA_BITWIDTH-1:0] r_out_data;

  logic                     w_hs;
  logic [ADDR_BITWIDTH-1:0] w_cur_num;
  logic                     w_last;
  logic                     w_issue;
  logic                     w_drain_end;

  assign in_ready  = (r_state == S_IACT) || (r_state == S_WGHT);
  assign w_hs      = in_valid && in_ready;
  assign w_cur_num = (r_state == S_IACT) ? r_num_iact : r_num_wght;
  assign w_last    = (r_cnt == (w_cur_num - L_ONE));

  // The output slot doubles as the in-flight marker: it is claimed
  // when a read issues, so at most one word is ever outstanding.
  assign w_issue = (r_state == S_DRAIN)
                && (r_cnt != r_num_psum)
                && (!r_out_valid || psum_out_ready);

  // All reads issued and the held word leaves: that was the last one.
  assign w_drain_end = (r_state == S_DRAIN)
                    && r_out_valid && psum_out_ready
                    && (r_cnt == r_num_psum);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_iact != '0)      w_next = S_IACT;
          else if (num_wght != '0) w_next = S_WGHT;
          else                     w_next = S_COMP;
        end
      end
      S_IACT: begin
        if (w_hs && w_last)
          w_next = (r_num_wght != '0) ? S_WGHT : S_COMP;
      end
      S_WGHT: begin
        if (w_hs && w_last) w_next = S_COMP;
      end
      S_COMP: begin
        if (compute_done)
          w_next = (r_num_psum != '0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (w_drain_end) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_num_iact  <= '0;
      r_num_wght  <= '0;
      r_num_psum  <= '0;
      r_we_iact   <= 1'b0;
      r_wa_iact   <= '0;
      r_wd_iact   <= '0;
      r_we_wght   <= 1'b0;
      r_wa_wght   <= '0;
      r_wd_wght   <= '0;
      r_cstart    <= 1'b0;
      r_out_valid <= 1'b0;
      r_fresh     <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state   <= w_next;
      r_we_iact <= 1'b0;
      r_we_wght <= 1'b0;
      r_cstart  <= (w_next == S_COMP) && (r_state != S_COMP);
      r_fresh   <= w_issue;

      if ((r_state == S_IDLE) && start) begin
        r_num_iact <= num_iact;
        r_num_wght <= num_wght;
        r_num_psum <= num_psum;
        r_cnt      <= '0;
      end

      if (w_hs) begin
        if (r_state == S_IACT) begin
          r_we_iact <= 1'b1;
          r_wa_iact <= r_cnt;
          r_wd_iact <= in_data;
        end else begin
          r_we_wght <= 1'b1;
          r_wa_wght <= r_cnt;
          r_wd_wght <= in_data;
        end
        r_cnt <= w_last ? '0 : r_cnt + L_ONE;
      end

      if (w_issue) r_cnt <= r_cnt + L_ONE;

      if (w_issue)             r_out_valid <= 1'b1;
      else if (psum_out_ready) r_out_valid <= 1'b0;

      // Capture the GLB word on its arrival cycle so it stays put
      // under backpressure even if the GLB output later changes.
      if (r_fresh)                r_out_data <= r_data_psum;
      else if (r_state == S_DONE) r_out_data <= '0;
    end
  end

  assign write_en_iact  = r_we_iact;
  assign w_addr_iact    = r_wa_iact;
  assign w_data_iact    = r_wd_iact;
  assign write_en_wght  = r_we_wght;
  assign w_addr_wght    = r_wa_wght;
  assign w_data_wght    = r_wd_wght;
  assign read_req_psum  = w_issue;
  assign r_addr_psum    = w_issue ? r_cnt : '0;
  // Word is presented straight from the GLB in its arrival cycle,
  // which gives valid one cycle after the read request.
  assign psum_out_data  = r_fresh ? r_data_psum : r_out_data;
  assign psum_out_valid = r_out_valid;
  assign compute_start  = r_cstart;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);

endmodule

// File: tb/tb_glb_cluster_seq.sv
// tb_glb_cluster_seq: self-checking bench for glb_cluster_seq.
// Job table plus hand-written reset sequence; queue-based scoreboard.
module tb_glb_cluster_seq;
  localparam int DW = 16;
  localparam int AW = 10;

  typedef struct packed {
    logic          glb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int         ni;
    int         nw;
    int         np;
    bit         gap;
    logic [3:0] rdy;
    bit         sic;
    int         e_iact;
    int         e_wght;
    int         e_rd;
    int         e_cs;
  } job_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] num_iact;
  logic [AW-1:0] num_wght;
  logic [AW-1:0] num_psum;
  logic          compute_done;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          write_en_iact;
  logic [AW-1:0] w_addr_iact;
  logic [DW-1:0] w_data_iact;
  logic          write_en_wght;
  logic [AW-1:0] w_addr_wght;
  logic [DW-1:0] w_data_wght;
  logic          read_req_psum;
  logic [AW-1:0] r_addr_psum;
  logic [DW-1:0] r_data_psum;
  logic [DW-1:0] psum_out_data;
  logic          psum_out_valid;
  logic          psum_out_ready;
  logic          compute_start;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  glb_cluster_seq #(
    .DATA_BITWIDTH(DW),
    .ADDR_BITWIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_iact(num_iact),
    .num_wght(num_wght),
    .num_psum(num_psum),
    .compute_done(compute_done),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .write_en_iact(write_en_iact),
    .w_addr_iact(w_addr_iact),
    .w_data_iact(w_data_iact),
    .write_en_wght(write_en_wght),
    .w_addr_wght(w_addr_wght),
    .w_data_wght(w_data_wght),
    .read_req_psum(read_req_psum),
    .r_addr_psum(r_addr_psum),
    .r_data_psum(r_data_psum),
    .psum_out_data(psum_out_data),
    .psum_out_valid(psum_out_valid),
    .psum_out_ready(psum_out_ready),
    .compute_start(compute_start),
    .busy(busy),
    .done(done)
  );

  logic [DW-1:0] psum_mem [16];

  always @(posedge clk)
    if (read_req_psum) r_data_psum <= psum_mem[r_addr_psum[3:0]];

  int            n_checks = 0;
  int            n_errors = 0;
  int            c_iact, c_wght, c_rd, c_cs, c_done, c_out;
  wr_t           wr_q[$];
  logic [DW-1:0] out_q[$];
  logic          hold_v;
  logic [DW-1:0] hold_d;
  job_t          jobs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got unexpected output, expected none queued", nm);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (write_en_iact) begin
        c_iact++;
        if (wr_q.size() == 0) miss("iact_wr");
        else chk("iact_wr", 32'({1'b0, w_addr_iact, w_data_iact}),
                 32'(wr_q.pop_front()));
      end
      if (write_en_wght) begin
        c_wght++;
        if (wr_q.size() == 0) miss("wght_wr");
        else chk("wght_wr", 32'({1'b1, w_addr_wght, w_data_wght}),
                 32'(wr_q.pop_front()));
      end
      if (read_req_psum) c_rd++;
      if (compute_start) c_cs++;
      if (done) c_done++;
      if (hold_v) begin
        chk("hold_valid", 32'(psum_out_valid), 32'd1);
        chk("hold_data", 32'(psum_out_data), 32'(hold_d));
      end
      if (psum_out_valid && psum_out_ready) begin
        c_out++;
        if (out_q.size() == 0) miss("psum_out");
        else chk("psum_out", 32'(psum_out_data),
                 32'(out_q.pop_front()));
      end
      hold_v = psum_out_valid && !psum_out_ready;
      hold_d = psum_out_data;
    end
  end

  task automatic clr_cnt();
    c_iact = 0; c_wght = 0; c_rd = 0;
    c_cs = 0; c_done = 0; c_out = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_any"}, 32'(|{in_ready, write_en_iact, w_addr_iact,
        w_data_iact, write_en_wght, w_addr_wght, w_data_wght,
        read_req_psum, r_addr_psum, psum_out_valid, psum_out_data,
        compute_start, busy, done}), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_we_wght"}, 32'(write_en_wght), 32'd0);
  endtask

  task automatic run_job(input int idx, input job_t j,
                         input logic [DW-1:0] dbase);
    int k;
    int tot;
    int cyc;
    int i;
    clr_cnt();
    for (int n = 0; n < j.np; n++) out_q.push_back(psum_mem[n]);
    @(posedge clk); #1;
    start = 1'b1;
    num_iact = AW'(j.ni);
    num_wght = AW'(j.nw);
    num_psum = AW'(j.np);
    @(posedge clk); #1;
    start = 1'b0;
    num_iact = '0; num_wght = '0; num_psum = '0;
    @(negedge clk);
    chk($sformatf("j%0d_busy_start", idx), 32'(busy), 32'd1);

    tot = j.ni + j.nw;
    k = 0;
    cyc = 0;
    while (k < tot && cyc < 100) begin
      @(posedge clk); #1;
      in_valid = j.gap ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = DW'(dbase + DW'(k));
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (k < j.ni) wr_q.push_back({1'b0, AW'(k), in_data});
        else wr_q.push_back({1'b1, AW'(k - j.ni), in_data});
        k++;
      end
      cyc++;
    end
    chk($sformatf("j%0d_load_words", idx), 32'(k), 32'(tot));
    @(posedge clk); #1;
    in_valid = 1'b0;

    cyc = 0;
    while (c_cs == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("j%0d_busy_comp", idx), 32'(busy), 32'd1);
    if (j.sic) begin
      start = 1'b1;
      num_iact = 10'd7; num_wght = 10'd7; num_psum = 10'd7;
      @(posedge clk); #1;
      start = 1'b0;
      num_iact = '0; num_wght = '0; num_psum = '0;
    end
    compute_done = 1'b1;
    @(posedge clk); #1;
    compute_done = 1'b0;

    i = 0;
    cyc = 0;
    while (c_done == 0 && cyc < 200) begin
      psum_out_ready = j.rdy[i % 4];
      i++;
      @(negedge clk);
      cyc++;
      @(posedge clk); #1;
    end
    psum_out_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("j%0d_busy_after_done", idx), 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk($sformatf("j%0d_done_pulses", idx), 32'(c_done), 32'd1);
    chk($sformatf("j%0d_iact_writes", idx), 32'(c_iact), 32'(j.e_iact));
    chk($sformatf("j%0d_wght_writes", idx), 32'(c_wght), 32'(j.e_wght));
    chk($sformatf("j%0d_psum_reads", idx), 32'(c_rd), 32'(j.e_rd));
    chk($sformatf("j%0d_cstart", idx), 32'(c_cs), 32'(j.e_cs));
    chk($sformatf("j%0d_out_words", idx), 32'(c_out), 32'(j.np));
    chk($sformatf("j%0d_wr_left", idx), 32'(wr_q.size()), 32'd0);
    chk($sformatf("j%0d_out_left", idx), 32'(out_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    num_iact = '0; num_wght = '0; num_psum = '0;
    compute_done = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    psum_out_ready = 1'b0;
    r_data_psum = '0;
    hold_v = 1'b0;
    hold_d = '0;
    for (int i = 0; i < 16; i++) psum_mem[i] = DW'(16'h00A0 + i);

    //            ni nw np gap rdy     sic  e_iact e_wght e_rd e_cs
    jobs[0] = '{4, 3, 2, 1'b0, 4'b1111, 1'b0, 4, 3, 2, 1};
    jobs[1] = '{0, 2, 1, 1'b0, 4'b1111, 1'b0, 0, 2, 1, 1};
    jobs[2] = '{1, 1, 3, 1'b0, 4'b1001, 1'b1, 1, 1, 3, 1};
    jobs[3] = '{2, 0, 0, 1'b0, 4'b1111, 1'b0, 2, 0, 0, 1};
    jobs[4] = '{0, 0, 0, 1'b0, 4'b1111, 1'b0, 0, 0, 0, 1};
    jobs[5] = '{3, 2, 4, 1'b1, 4'b0110, 1'b0, 3, 2, 4, 1};

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    clr_cnt();
    @(posedge clk); #1;
    start = 1'b1;
    num_iact = 10'd2; num_wght = 10'd3; num_psum = 10'd1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h0100;
    k = 0;
    cyc = 0;
    while (c_wght == 0 && cyc < 20) begin
      @(negedge clk);
      if (in_ready) begin
        if (k < 2) wr_q.push_back({1'b0, AW'(k), in_data});
        else wr_q.push_back({1'b1, AW'(k - 2), in_data});
        k++;
      end
      @(posedge clk); #1;
      in_data = DW'(16'h0100 + k);
      cyc++;
    end
    chk("pre_reset_we_wght", 32'(write_en_wght), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("reset_mid_load");
    wr_q.delete();
    out_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;

    for (int j = 0; j < 6; j++)
      run_job(j, jobs[j], DW'(1 + 32 * j));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/glb_cluster_seq.md
# glb_cluster_seq

Sequencer for one GLB cluster (iact, weight and psum global buffers). It accepts a single input stream and fills the iact GLB, then the weight GLB. It then waits for the PE cluster to finish computing, and finally drains the psum GLB to an output stream. It sits between the top-level DMA/stream interface and the GLB cluster, and drives every GLB write and read port except the inter-cluster psum read path.

## Interface
Parameters
- DATA_BITWIDTH, 16, GLB word and stream width
- ADDR_BITWIDTH, 10, GLB address and count width

Ports
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job start; honoured only in IDLE
- num_iact / num_wght / num_psum  in  ADDR_BITWIDTH each  word counts, latched at start
- compute_done  in  1  PE cluster finished; sampled only in COMPUTE
- in_data  in  DATA_BITWIDTH  load stream data
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- write_en_iact, w_addr_iact, w_data_iact  out  1/ADDR/DATA  iact GLB write port
- write_en_wght, w_addr_wght, w_data_wght  out  1/ADDR/DATA  weight GLB write port
- read_req_psum, r_addr_psum  out  1/ADDR  psum GLB read port
- r_data_psum  in  DATA_BITWIDTH  psum GLB read data, valid the cycle after read_req_psum
- psum_out_data  out  DATA_BITWIDTH  drain stream data
- psum_out_valid  out  1  drain stream valid
- psum_out_ready  in  1  drain stream ready
- compute_start  out  1  one-cycle pulse on entering COMPUTE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the job completes

## Operation
- States: IDLE, LOAD_IACT, LOAD_WGHT, COMPUTE, DRAIN, DONE.
- IDLE: start=1 latches the three counts and clears the word counter.
  - Next state is the first of LOAD_IACT, LOAD_WGHT or COMPUTE whose preceding counts are non-zero; zero-count phases are skipped.
- LOAD_IACT / LOAD_WGHT:
  - in_ready=1 (combinational from state).
  - Each handshake (in_valid & in_ready) registers a write on the next cycle: write_en=1, w_addr=counter, w_data=in_data. The counter then increments.
  - On the handshake with counter==count-1, the counter clears and the state advances.
- COMPUTE: compute_start pulses for the first cycle. Remain until compute_done=1, then go to DRAIN, or to DONE if num_psum==0.
- DRAIN:
  - At most one psum read in flight.
  - Issue read_req_psum with r_addr_psum=counter when no read is pending and the output register is empty, or is being consumed this cycle.
  - The following cycle, r_data_psum is loaded into psum_out_data and psum_out_valid=1, held until psum_out_ready.
  - After the last word is accepted, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. Counts are captured as unsigned; count 2^ADDR_BITWIDTH is not representable.
- Address counters never wrap within a job, because count ≤ 2^ADDR_BITWIDTH−1.

## Timing
- Reset (asynchronous, any state): state=IDLE, counters=0, and every output is 0. This includes in_ready, write_en_*, w_addr_*, w_data_*, read_req_psum, r_addr_psum, psum_out_valid, psum_out_data, compute_start, busy and done. An in-flight read is discarded.
- Load throughput: 1 word/cycle. Handshake in cycle t gives the GLB write in cycle t+1.
- Drain throughput: with psum_out_ready held high, read issued at t, psum_out_valid at t+1, next read at t+1, so 1 word/cycle after the first.
- Output backpressure: psum_out_data/valid stay stable while psum_out_ready=0.
- start→busy: 1 cycle. Last load handshake→COMPUTE: next cycle. compute_done→DRAIN: next cycle.

## Test plan
- Reset mid-LOAD_WGHT with in_valid=1 → all outputs 0 the same cycle. A new start then restarts from address 0.
- start with num_iact=4, num_wght=3, num_psum=2 and continuous in_valid (data 1..7) → iact writes addr 0–3 with data 1–4, then wght writes addr 0–2 with data 5–7. compute_start pulses once.
- num_iact=0, num_wght=2 → LOAD_IACT skipped. The first handshake writes the weight GLB at addr 0, and write_en_iact never asserts.
- DRAIN with psum_out_ready toggling 1,0,0,1 and psum GLB preset to 0xA0,0xA1,0xA2 → stream outputs 0xA0,0xA1,0xA2 in order, with data held stable while ready=0. Then done pulses exactly once.
- start pulsed during COMPUTE → ignored; counts unchanged. compute_done later → DRAIN of the original num_psum words.
- num_psum=0 → COMPUTE → DONE, read_req_psum never asserts, then busy falls the cycle after done.
